// File: rtl/decode_stage_if.sv
// Decoded control bundle carried from the decode stage to execute/memory/writeback.
interface controlsgs_if;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [1:0]  alu_a_sel;
    logic        alu_b_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [1:0]  result_src;
    logic        branch;
    logic [2:0]  branch_funct3;
    logic        jump;
    logic        jalr;
    logic        illegal;

    modport producer (
        output rs1, rs2, rd, imm, alu_op, alu_a_sel, alu_b_imm, reg_write,
               mem_read, mem_write, mem_funct3, result_src, branch,
               branch_funct3, jump, jalr, illegal
    );

    modport consumer (
        input rs1, rs2, rd, imm, alu_op, alu_a_sel, alu_b_imm, reg_write,
              mem_read, mem_write, mem_funct3, result_src, branch,
              branch_funct3, jump, jalr, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I instruction decoder: combinational control bundle plus a sticky illegal flag.
module decode_stage (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr,
    controlsgs_if.producer        controlsgs_io,
    output logic                  illegal_sticky
);
    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [XLEN-1:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [XLEN-1:0] INSN_EBREAK = 32'h0010_0073;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [XLEN-1:0] imm;
    alu_op_e         alu_op;
    logic [1:0]      alu_a_sel;
    logic            alu_b_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [1:0]      result_src;
    logic            branch;
    logic [2:0]      branch_funct3;
    logic            jump;
    logic            jalr;
    logic            illegal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd     = instr[11:7];

    // Immediate formats, all sign-extended from instr[31].
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Opcode decode, then suppress side effects for illegal encodings and writes to x0.
    always_comb begin
        imm           = '0;
        alu_op        = ALU_ADD;
        alu_a_sel     = 2'd0;
        alu_b_imm     = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        result_src    = 2'd0;
        branch        = 1'b0;
        branch_funct3 = 3'b000;
        jump          = 1'b0;
        jalr          = 1'b0;
        illegal       = 1'b0;

        case (opcode)
            OPC_R: begin
                reg_write = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: alu_op = ALU_ADD;
                    {7'h20, 3'b000}: alu_op = ALU_SUB;
                    {7'h00, 3'b001}: alu_op = ALU_SLL;
                    {7'h00, 3'b010}: alu_op = ALU_SLT;
                    {7'h00, 3'b011}: alu_op = ALU_SLTU;
                    {7'h00, 3'b100}: alu_op = ALU_XOR;
                    {7'h00, 3'b101}: alu_op = ALU_SRL;
                    {7'h20, 3'b101}: alu_op = ALU_SRA;
                    {7'h00, 3'b110}: alu_op = ALU_OR;
                    {7'h00, 3'b111}: alu_op = ALU_AND;
                    default:         illegal = 1'b1;
                endcase
            end
            OPC_IMM: begin
                imm       = imm_i;
                alu_b_imm = 1'b1;
                reg_write = 1'b1;
                case (funct3)
                    3'b000: alu_op = ALU_ADD;
                    3'b001: begin
                        alu_op  = ALU_SLL;
                        illegal = (funct7 != 7'h00);
                    end
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b101: begin
                        if (funct7 == 7'h00)      alu_op = ALU_SRL;
                        else if (funct7 == 7'h20) alu_op = ALU_SRA;
                        else                      illegal = 1'b1;
                    end
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                imm        = imm_i;
                alu_b_imm  = 1'b1;
                mem_read   = 1'b1;
                result_src = 2'd1;
                reg_write  = 1'b1;
                illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                imm       = imm_s;
                alu_b_imm = 1'b1;
                mem_write = 1'b1;
                illegal   = funct3[2] || (funct3 == 3'b011);
            end
            OPC_BRANCH: begin
                imm           = imm_b;
                branch        = 1'b1;
                branch_funct3 = funct3;
                alu_op        = ALU_SUB;
                illegal       = (funct3[2:1] == 2'b01);
            end
            OPC_JAL: begin
                imm        = imm_j;
                jump       = 1'b1;
                alu_a_sel  = 2'd1;
                alu_b_imm  = 1'b1;
                result_src = 2'd2;
                reg_write  = 1'b1;
            end
            OPC_JALR: begin
                imm        = imm_i;
                jump       = 1'b1;
                jalr       = 1'b1;
                alu_b_imm  = 1'b1;
                result_src = 2'd2;
                reg_write  = 1'b1;
                illegal    = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                imm       = imm_u;
                alu_a_sel = 2'd2;
                alu_b_imm = 1'b1;
                reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                imm       = imm_u;
                alu_a_sel = 2'd1;
                alu_b_imm = 1'b1;
                reg_write = 1'b1;
            end
            OPC_FENCE: begin
                illegal = 1'b0;
            end
            OPC_SYSTEM: begin
                illegal = (instr != INSN_ECALL) && (instr != INSN_EBREAK);
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            branch    = 1'b0;
            jump      = 1'b0;
            jalr      = 1'b0;
        end
        if (rd == 5'd0) begin
            reg_write = 1'b0;
        end
    end

    // Drive the bundle; register indices are always the raw fields.
    assign controlsgs_io.rs1           = instr[19:15];
    assign controlsgs_io.rs2           = instr[24:20];
    assign controlsgs_io.rd            = rd;
    assign controlsgs_io.imm           = imm;
    assign controlsgs_io.alu_op        = alu_op;
    assign controlsgs_io.alu_a_sel     = alu_a_sel;
    assign controlsgs_io.alu_b_imm     = alu_b_imm;
    assign controlsgs_io.reg_write     = reg_write;
    assign controlsgs_io.mem_read      = mem_read;
    assign controlsgs_io.mem_write     = mem_write;
    assign controlsgs_io.mem_funct3    = funct3;
    assign controlsgs_io.result_src    = result_src;
    assign controlsgs_io.branch        = branch;
    assign controlsgs_io.branch_funct3 = branch_funct3;
    assign controlsgs_io.jump          = jump;
    assign controlsgs_io.jalr          = jalr;
    assign controlsgs_io.illegal       = illegal;

    // Sticky illegal flag; reset wins over a same-edge illegal decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_sticky <= 1'b0;
        end else if (illegal) begin
            illegal_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus randomized instructions vs a reference model.
module tb_decode_stage;
    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        illegal_sticky;

    int checks;
    int errors;
    logic exp_sticky;

    controlsgs_if cif ();

    decode_stage dut (
        .clk            (clk),
        .rst            (rst),
        .instr          (instr),
        .controlsgs_io  (cif),
        .illegal_sticky (illegal_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic [1:0]  a_sel;
        logic        b_imm;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [1:0]  rsrc;
        logic        br;
        logic [2:0]  bf3;
        logic        jmp;
        logic        jalr;
        logic        ill;
    } exp_t;

    // ALU codes for funct3 0..7 in their "plain" variant (ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND).
    localparam logic [31:0] BASE_OP = {4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd0};

    function automatic logic ref_legal(input logic [31:0] i);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = i[14:12];
        f7 = i[31:25];
        case (i[6:0])
            7'b0110011: return (f7 == 7'h00) || (f7 == 7'h20 && (f3 inside {3'd0, 3'd5}));
            7'b0010011: begin
                if (f3 == 3'd1) return f7 == 7'h00;
                if (f3 == 3'd5) return f7 inside {7'h00, 7'h20};
                return 1'b1;
            end
            7'b0000011: return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            7'b0100011: return f3 < 3'd3;
            7'b1100011: return !(f3 inside {3'd2, 3'd3});
            7'b1100111: return f3 == 3'd0;
            7'b1101111, 7'b0110111, 7'b0010111, 7'b0001111: return 1'b1;
            7'b1110011: return (i == 32'h0000_0073) || (i == 32'h0010_0073);
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t ref_model(input logic [31:0] i);
        exp_t e;
        logic [2:0]  f3;
        logic [31:0] ii, is, ib, iu, ij;
        logic [3:0]  base;
        f3   = i[14:12];
        ii   = 32'($signed(i) >>> 20);
        is   = {ii[31:5], i[11:7]};
        ib   = (is & ~32'h0000_0801) | (32'(i[7]) << 11);
        iu   = i & 32'hFFFF_F000;
        ij   = (ii & 32'hFFF0_07FE) | (i & 32'h000F_F000) | (32'(i[20]) << 11);
        base = BASE_OP[{f3, 2'b00} +: 4];
        e    = '0;
        e.ill = !ref_legal(i);
        case (i[6:0])
            7'b0110011: begin
                e.rw = 1'b1;
                e.alu_op = base + 4'((i[30] && (f3 inside {3'd0, 3'd5})) ? 1 : 0);
            end
            7'b0010011: begin
                e.imm = ii; e.b_imm = 1'b1; e.rw = 1'b1;
                e.alu_op = base + 4'((i[30] && f3 == 3'd5) ? 1 : 0);
            end
            7'b0000011: begin
                e.imm = ii; e.b_imm = 1'b1; e.mr = 1'b1; e.rsrc = 2'd1; e.rw = 1'b1;
            end
            7'b0100011: begin
                e.imm = is; e.b_imm = 1'b1; e.mw = 1'b1;
            end
            7'b1100011: begin
                e.imm = ib; e.br = 1'b1; e.bf3 = f3; e.alu_op = 4'd1;
            end
            7'b1101111: begin
                e.imm = ij; e.jmp = 1'b1; e.a_sel = 2'd1; e.b_imm = 1'b1; e.rsrc = 2'd2; e.rw = 1'b1;
            end
            7'b1100111: begin
                e.imm = ii; e.jmp = 1'b1; e.jalr = 1'b1; e.b_imm = 1'b1; e.rsrc = 2'd2; e.rw = 1'b1;
            end
            7'b0110111: begin
                e.imm = iu; e.a_sel = 2'd2; e.b_imm = 1'b1; e.rw = 1'b1;
            end
            7'b0010111: begin
                e.imm = iu; e.a_sel = 2'd1; e.b_imm = 1'b1; e.rw = 1'b1;
            end
            default: ;
        endcase
        if (e.ill) begin
            e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0; e.jmp = 1'b0; e.jalr = 1'b0;
        end
        if (i[11:7] == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s instr=%h observed=%h expected=%h", tag, instr, obs, expv);
        end
    endtask

    task automatic check_decode(input logic [31:0] i);
        exp_t e;
        e = ref_model(i);
        chk("rs1", 32'(cif.rs1), 32'(i[19:15]));
        chk("rs2", 32'(cif.rs2), 32'(i[24:20]));
        chk("rd", 32'(cif.rd), 32'(i[11:7]));
        chk("illegal", 32'(cif.illegal), 32'(e.ill));
        chk("reg_write", 32'(cif.reg_write), 32'(e.rw));
        chk("mem_read", 32'(cif.mem_read), 32'(e.mr));
        chk("mem_write", 32'(cif.mem_write), 32'(e.mw));
        chk("branch", 32'(cif.branch), 32'(e.br));
        chk("jump", 32'(cif.jump), 32'(e.jmp));
        chk("jalr", 32'(cif.jalr), 32'(e.jalr));
        if (!e.ill) begin
            chk("imm", cif.imm, e.imm);
            chk("alu_op", 32'(cif.alu_op), 32'(e.alu_op));
            chk("alu_a_sel", 32'(cif.alu_a_sel), 32'(e.a_sel));
            chk("alu_b_imm", 32'(cif.alu_b_imm), 32'(e.b_imm));
            chk("result_src", 32'(cif.result_src), 32'(e.rsrc));
            chk("branch_funct3", 32'(cif.branch_funct3), 32'(e.bf3));
            if (e.mr || e.mw) chk("mem_funct3", 32'(cif.mem_funct3), 32'(i[14:12]));
        end
    endtask

    // Apply one instruction (and rst) for a cycle; check decode before the edge, sticky after it.
    task automatic step(input logic [31:0] i, input logic r);
        exp_t e;
        @(negedge clk);
        instr = i;
        rst   = r;
        #1;
        check_decode(i);
        e = ref_model(i);
        @(posedge clk);
        if (r) exp_sticky = 1'b0;
        else if (e.ill) exp_sticky = 1'b1;
        #1;
        chk("illegal_sticky", 32'(illegal_sticky), 32'(exp_sticky));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        int unsigned sel;
        i   = $urandom;
        sel = $urandom_range(0, 12);
        case (sel)
            0:  i[6:0] = 7'b0110011;
            1:  i[6:0] = 7'b0010011;
            2:  i[6:0] = 7'b0000011;
            3:  i[6:0] = 7'b0100011;
            4:  i[6:0] = 7'b1100011;
            5:  i[6:0] = 7'b1101111;
            6:  i[6:0] = 7'b1100111;
            7:  i[6:0] = 7'b0110111;
            8:  i[6:0] = 7'b0010111;
            9:  i[6:0] = 7'b0001111;
            10: i = ($urandom_range(0, 3) == 0) ? i : (($urandom_range(0, 1) == 0) ? 32'h0000_0073 : 32'h0010_0073);
            11: i[6:0] = 7'b0110011;
            default: ;
        endcase
        if (sel == 10) i[6:0] = 7'b1110011;
        case ($urandom_range(0, 3))
            0: i[31:25] = 7'h00;
            1: i[31:25] = 7'h20;
            default: ;
        endcase
        if (sel == 10 && i[31:7] != 25'd0 && i[31:7] != 25'h2000) i[14:12] = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) i[14:12] = 3'd0;
        return i;
    endfunction

    initial begin
        checks     = 0;
        errors     = 0;
        exp_sticky = 1'b0;
        rst        = 1'b1;
        instr      = 32'h0000_0013;

        step(32'h0000_0013, 1'b1);
        chk("reset_sticky", 32'(illegal_sticky), 32'd0);

        step(32'h0050_0093, 1'b0);
        chk("addi_imm", cif.imm, 32'h0000_0005);
        chk("addi_rw", 32'(cif.reg_write), 32'd1);

        step(32'h4020_8033, 1'b0);
        chk("sub_op", 32'(cif.alu_op), 32'd1);
        chk("sub_rw_x0", 32'(cif.reg_write), 32'd0);

        step(32'h0040_A183, 1'b0);
        chk("lw_mf3", 32'(cif.mem_funct3), 32'd2);
        chk("lw_rsrc", 32'(cif.result_src), 32'd1);

        step(32'h0020_A223, 1'b0);
        chk("sw_mw", 32'(cif.mem_write), 32'd1);
        chk("sw_imm", cif.imm, 32'h0000_0004);

        step(32'hFE20_9EE3, 1'b0);
        chk("bne_imm", cif.imm, 32'hFFFF_FFFC);
        chk("bne_bf3", 32'(cif.branch_funct3), 32'd1);

        step(32'h0080_00EF, 1'b0);
        chk("jal_imm", cif.imm, 32'h0000_0008);
        chk("jal_rsrc", 32'(cif.result_src), 32'd2);

        step(32'h1234_52B7, 1'b0);
        chk("lui_imm", cif.imm, 32'h1234_5000);
        chk("lui_asel", 32'(cif.alu_a_sel), 32'd2);

        step(32'h0000_0097, 1'b0);
        chk("auipc_asel", 32'(cif.alu_a_sel), 32'd1);

        step(32'h0000_0073, 1'b0);
        step(32'h0010_0073, 1'b0);
        chk("ebreak_legal_sticky", 32'(illegal_sticky), 32'd0);

        step(32'h0000_0000, 1'b0);
        chk("zero_illegal", 32'(cif.illegal), 32'd1);
        chk("sticky_set", 32'(illegal_sticky), 32'd1);

        step(32'h0050_0093, 1'b0);
        chk("sticky_hold", 32'(illegal_sticky), 32'd1);

        step(32'h0000_0000, 1'b1);
        chk("sticky_rst_priority", 32'(illegal_sticky), 32'd0);

        for (int n = 0; n < 400; n++) begin
            step(rand_instr(), ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
